// File: rtl/mips_mem_arbiter_pkg.sv
// Shared types for the MIPS memory arbiter: FSM state encoding and owner codes.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// Request/acknowledge memory bus; 'ack' is the done pulse on requester ports and mem_ack on the memory port.
interface mips_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mips_mem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Latency: count visible the cycle after inc/clr; no backpressure.
module mips_sat_counter #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != W'(MAX))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares one variable-latency memory between CPU and DMA ports, with DMA anti-starvation and access timeout.
// Latency: grant->mem_req 1 cycle, ack->done 1 cycle; requesters are held (cpu_stall) until their done.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16,
  parameter int MAX_WAIT   = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mips_mem_arbiter_if.slave  cpu_if,
  mips_mem_arbiter_if.slave  dma_if,
  mips_mem_arbiter_if.master mem_if,
  output logic               cpu_stall_o,
  output logic               err_o
);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(MAX_WAIT + 1);

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [WW-1:0]         wait_cnt_q, wait_cnt_d;
  logic                  cpu_done_q, cpu_done_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic                  dma_done_q, dma_done_d;
  logic [DATA_WIDTH-1:0] dma_rdata_q, dma_rdata_d;
  logic                  err_q, err_d;
  logic                  dma_grant, cpu_grant, finish;
  logic                  starve_inc, starve_clr;
  logic [SW-1:0]         starve_cnt;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wait_cnt_d  = wait_cnt_q;
    cpu_done_d  = 1'b0;
    cpu_rdata_d = '0;
    dma_done_d  = 1'b0;
    dma_rdata_d = '0;
    err_d       = 1'b0;
    dma_grant   = 1'b0;
    cpu_grant   = 1'b0;
    finish      = 1'b0;
    case (state_q)
      IDLE: begin
        dma_grant = dma_if.req && (!cpu_if.req || (starve_cnt == SW'(MAX_WAIT)));
        cpu_grant = cpu_if.req && !dma_grant;
        if (dma_grant || cpu_grant) begin
          owner_d     = dma_grant ? OWN_DMA : OWN_CPU;
          mem_we_d    = dma_grant ? dma_if.we : cpu_if.we;
          mem_addr_d  = dma_grant ? dma_if.addr : cpu_if.addr;
          mem_wdata_d = dma_grant ? dma_if.wdata : cpu_if.wdata;
          mem_req_d   = 1'b1;
          wait_cnt_d  = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        finish = mem_if.ack || (wait_cnt_q == WW'(TIMEOUT - 1));
        if (finish) begin
          // Done/rdata are registered so they land in the DONE cycle; timed-out reads return 0.
          mem_req_d = 1'b0;
          err_d     = !mem_if.ack;
          state_d   = DONE;
          if (owner_q == OWN_DMA) begin
            dma_done_d  = 1'b1;
            dma_rdata_d = mem_if.ack ? mem_if.rdata : '0;
          end else begin
            cpu_done_d  = 1'b1;
            cpu_rdata_d = mem_if.ack ? mem_if.rdata : '0;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wait_cnt_q  <= '0;
      cpu_done_q  <= 1'b0;
      cpu_rdata_q <= '0;
      dma_done_q  <= 1'b0;
      dma_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wait_cnt_q  <= wait_cnt_d;
      cpu_done_q  <= cpu_done_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_done_q  <= dma_done_d;
      dma_rdata_q <= dma_rdata_d;
      err_q       <= err_d;
    end
  end

  // DMA only starves while it waits and does not hold the memory itself.
  assign starve_clr = !dma_if.req || dma_grant;
  assign starve_inc = dma_if.req && !((state_q != IDLE) && (owner_q == OWN_DMA));

  mips_sat_counter #(.MAX(MAX_WAIT), .W(SW)) u_starve_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (starve_inc),
    .clr_i (starve_clr),
    .cnt_o (starve_cnt)
  );

  assign mem_if.req   = mem_req_q;
  assign mem_if.we    = mem_we_q;
  assign mem_if.addr  = mem_addr_q;
  assign mem_if.wdata = mem_wdata_q;
  assign cpu_if.ack   = cpu_done_q;
  assign cpu_if.rdata = cpu_rdata_q;
  assign dma_if.ack   = dma_done_q;
  assign dma_if.rdata = dma_rdata_q;
  assign err_o        = err_q;
  assign cpu_stall_o  = cpu_if.req & ~cpu_done_q;
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: per-cycle comparison against a transaction model plus literal checks.
`timescale 1ns/1ps
module tb_mips_mem_arbiter;
  localparam int AW = 32, DW = 32, TIMEOUT = 16, MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst;
  logic cpu_stall, err;

  mips_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) cpu_if ();
  mips_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dma_if ();
  mips_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

  mips_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cpu_if      (cpu_if),
    .dma_if      (dma_if),
    .mem_if      (mem_if),
    .cpu_stall_o (cpu_stall),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int cyc_n = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc_n++;

  // Memory responder: acks once mem_req has been high for 'lat' earlier cycles; 'stray' injects acks.
  int lat = 0, held = 0;
  bit stray = 1'b0;
  always @(posedge clk) begin
    #1;
    if (mem_if.req) begin
      mem_if.ack = stray || (held >= lat);
      held++;
    end else begin
      mem_if.ack = stray;
      held = 0;
    end
  end

  // Transaction model: one access in flight, then one completion cycle, then free to grant again.
  logic          e_req = 0, e_we = 0, e_cdone = 0, e_ddone = 0, e_err = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0, e_crd = '0, e_drd = '0;
  bit            m_active = 0, m_completing = 0, m_dma_owns = 0;
  int            m_waited = 0, m_starve = 0;

  always @(posedge clk) begin : model
    bit free, dma_g, cpu_g, dma_holds;
    int s_next;
    if (rst) begin
      {e_req, e_we, e_cdone, e_ddone, e_err} = '0;
      e_addr = '0; e_wdata = '0; e_crd = '0; e_drd = '0;
      m_active = 0; m_completing = 0; m_dma_owns = 0; m_waited = 0; m_starve = 0;
    end else begin
      free      = !m_active && !m_completing;
      dma_holds = !free && m_dma_owns;
      dma_g     = free && dma_if.req && (!cpu_if.req || m_starve == MAX_WAIT);
      cpu_g     = free && !dma_g && cpu_if.req;
      if (!dma_if.req || dma_g) s_next = 0;
      else if (dma_holds)       s_next = m_starve;
      else                      s_next = (m_starve + 1 > MAX_WAIT) ? MAX_WAIT : m_starve + 1;
      e_cdone = 0; e_ddone = 0; e_err = 0; e_crd = '0; e_drd = '0;
      if (m_completing) begin
        m_completing = 0;
      end else if (m_active) begin
        if (mem_if.ack || m_waited + 1 == TIMEOUT) begin
          m_active = 0; m_completing = 1; e_req = 0; e_err = !mem_if.ack;
          if (m_dma_owns) begin e_ddone = 1; e_drd = mem_if.ack ? mem_if.rdata : '0; end
          else            begin e_cdone = 1; e_crd = mem_if.ack ? mem_if.rdata : '0; end
        end else begin
          m_waited++;
        end
      end else if (dma_g || cpu_g) begin
        m_active = 1; m_waited = 0; m_dma_owns = dma_g; e_req = 1;
        e_we    = dma_g ? dma_if.we    : cpu_if.we;
        e_addr  = dma_g ? dma_if.addr  : cpu_if.addr;
        e_wdata = dma_g ? dma_if.wdata : cpu_if.wdata;
      end
      m_starve = s_next;
    end
  end

  // Per-cycle compare plus event counters used by the literal checks.
  int n_req, n_we40, n_cdone, n_ddone, n_errp, n_err_done, cdone_cyc, ddone_cyc;
  logic [DW-1:0] crd_last;
  always @(negedge clk) begin
    chk("mem_req",   mem_if.req,   e_req);
    chk("mem_we",    mem_if.we,    e_we);
    chk("mem_addr",  mem_if.addr,  e_addr);
    chk("mem_wdata", mem_if.wdata, e_wdata);
    chk("cpu_done",  cpu_if.ack,   e_cdone);
    chk("cpu_rdata", cpu_if.rdata, e_crd);
    chk("dma_done",  dma_if.ack,   e_ddone);
    chk("dma_rdata", dma_if.rdata, e_drd);
    chk("err",       err,          e_err);
    chk("cpu_stall", cpu_stall,    cpu_if.req & ~e_cdone);
    if (mem_if.req) n_req++;
    if (mem_if.req && mem_if.we && mem_if.addr == 32'h40) n_we40++;
    if (cpu_if.ack) begin n_cdone++; cdone_cyc = cyc_n; crd_last = cpu_if.rdata; end
    if (dma_if.ack) begin n_ddone++; ddone_cyc = cyc_n; end
    if (err) begin n_errp++; if (cpu_if.ack) n_err_done++; end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    n_req = 0; n_we40 = 0; n_cdone = 0; n_ddone = 0; n_errp = 0; n_err_done = 0;
    cdone_cyc = -1; ddone_cyc = -1; crd_last = '1;
  endtask

  task automatic cpu_start(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_if.we = we; cpu_if.addr = a; cpu_if.wdata = d; cpu_if.req = 1'b1;
  endtask

  task automatic cpu_finish(input string name);
    for (int i = 0; i < 60 && !cpu_if.ack; i++) cyc();
    chk(name, cpu_if.ack, 1'b1);
    cpu_if.req = 1'b0;
    cyc();
  endtask

  int c0, cdone_at_dma;

  initial begin
    rst = 1'b1;
    cpu_if.req = 0; cpu_if.we = 0; cpu_if.addr = '0; cpu_if.wdata = '0;
    dma_if.req = 0; dma_if.we = 0; dma_if.addr = '0; dma_if.wdata = '0;
    mem_if.ack = 0; mem_if.rdata = '0;
    repeat (3) cyc();
    chk("rst_mem_req", mem_if.req, 0);
    chk("rst_mem_addr", mem_if.addr, 0);
    chk("rst_done", {cpu_if.ack, dma_if.ack, err}, 0);
    cpu_if.req = 1'b1; #1;
    chk("rst_stall_follows_req", cpu_stall, 1);
    cpu_if.req = 1'b0;
    cyc(); rst = 1'b0; cyc();

    // 1) CPU read, zero wait states
    clr_cnt(); lat = 0; mem_if.rdata = 32'hDEADBEEF;
    cpu_start(1'b0, 32'h100, '0); c0 = cyc_n;
    cpu_finish("t1_done_seen");
    chk("t1_latency", cdone_cyc - c0, 2);
    chk("t1_rdata", crd_last, 32'hDEADBEEF);
    chk("t1_done_count", n_cdone, 1);

    // 2) CPU write, 3 wait states; port inputs scribbled mid-access
    clr_cnt(); lat = 3; mem_if.rdata = 32'h0BAD0BAD;
    cpu_start(1'b1, 32'h40, 32'h1234); c0 = cyc_n;
    cyc(); cpu_if.addr = 32'h80; cpu_if.wdata = 32'h5555;
    cpu_finish("t2_done_seen");
    chk("t2_we_addr_cycles", n_we40, 4);
    chk("t2_req_cycles", n_req, 4);
    chk("t2_done_count", n_cdone, 1);
    repeat (2) cyc();

    // 3) CPU holds req continuously; DMA wins once starvation saturates
    clr_cnt(); lat = 0; mem_if.rdata = 32'h11112222;
    dma_if.we = 1; dma_if.addr = 32'h200; dma_if.wdata = 32'hA5A5A5A5; dma_if.req = 1;
    cpu_start(1'b0, 32'h10, '0); c0 = cyc_n;
    for (int i = 0; i < 40 && !dma_if.ack; i++) cyc();
    chk("t3_dma_done_seen", dma_if.ack, 1);
    cdone_at_dma = n_cdone;
    dma_if.req = 0;
    cpu_finish("t3_cpu_resumes");
    chk("t3_dma_latency", ddone_cyc - c0, 8);
    chk("t3_cpu_before_dma", cdone_at_dma, 2);
    chk("t3_cpu_resume_cycle", cdone_cyc - c0, 11);
    chk("t3_dma_done_count", n_ddone, 1);
    repeat (2) cyc();

    // stray acks while idle must be ignored
    stray = 1; repeat (3) cyc(); stray = 0; cyc();

    // 4) simultaneous requests with no starvation: CPU first, DMA next
    clr_cnt(); lat = 0; mem_if.rdata = 32'h33334444;
    dma_if.we = 0; dma_if.addr = 32'h300; dma_if.req = 1;
    cpu_start(1'b0, 32'h20, '0); c0 = cyc_n;
    for (int i = 0; i < 40 && !dma_if.ack; i++) begin
      cyc();
      if (cpu_if.ack) cpu_if.req = 0;
    end
    chk("t4_dma_done_seen", dma_if.ack, 1);
    dma_if.req = 0; cyc();
    chk("t4_cpu_latency", cdone_cyc - c0, 2);
    chk("t4_dma_latency", ddone_cyc - c0, 5);
    repeat (2) cyc();

    // 5) no ack: timeout after TIMEOUT cycles of mem_req
    clr_cnt(); lat = 1000; mem_if.rdata = 32'hCAFEF00D;
    cpu_start(1'b0, 32'h44, '0); c0 = cyc_n;
    cpu_finish("t5_done_seen");
    chk("t5_req_cycles", n_req, 16);
    chk("t5_done_cycle", cdone_cyc - c0, 17);
    chk("t5_err_count", n_errp, 1);
    chk("t5_err_with_done", n_err_done, 1);
    chk("t5_rdata_zero", crd_last, 0);
    repeat (2) cyc();

    // 6) reset in BUSY abandons the access
    clr_cnt(); lat = 1000;
    cpu_start(1'b0, 32'h48, '0);
    cyc(); cyc();
    chk("t6_busy_before_rst", mem_if.req, 1);
    rst = 1; cpu_if.req = 0;
    cyc();
    chk("t6_req_dropped", mem_if.req, 0);
    cyc(); rst = 0; repeat (3) cyc();
    chk("t6_no_done", n_cdone + n_ddone + n_errp, 0);
    clr_cnt(); lat = 0; mem_if.rdata = 32'h0000600D;
    cpu_start(1'b0, 32'h4C, '0); c0 = cyc_n;
    cpu_finish("t6_fresh_done_seen");
    chk("t6_fresh_latency", cdone_cyc - c0, 2);
    chk("t6_fresh_rdata", crd_last, 32'h0000600D);
    repeat (2) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end
endmodule
